systolic_operand_feeder: RTL and testbench
==========================================

# systolic_operand_feeder

Skewing input stage that sits directly upstream of `systolic_array_top` on its left (row-operand) edge. It accepts one column slice of the left matrix per valid/ready beat, one element per array row. It delays lane i by i cycles so operands enter the array as a diagonal wavefront. It frames each tile as exactly `INNER_DIMENSION` beats, then drains the skew pipeline and pulses `tile_done`.

## Interface
- `LANES`, 50: number of array rows fed; matches `LEFT_MATRIX_ROW`.
- `INNER_DIMENSION`, 50: beats per tile (K).
- `DATA_WIDTH`, 8: element width.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  array advance enable; low freezes every register in this block.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_data`  in  LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `in_last`  in  1  upstream marks the final beat of a tile; checked only with the macro.
- `out_data`  out  LANES*DATA_WIDTH  skewed operands to the array edge, same packing.
- `out_lane_valid`  out  LANES  per-lane qualifier for `out_data`.
- `busy`  out  1  tile in progress or skew pipeline non-empty.
- `tile_done`  out  1  one-cycle pulse when the final beat exits lane LANES-1.
- `len_err`  out  1  sticky framing error; present only with `SYSTOLIC_FEEDER_CHECK_EN`.

## Operation
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE → STREAM on the first accepted beat.
  - STREAM → DRAIN on acceptance of beat number `INNER_DIMENSION` (beat counter reaches K-1).
  - DRAIN → IDLE when the drain counter reaches LANES-1 and `tile_done` fires.
- `in_ready = en && (state != DRAIN)`. Upstream may drop `in_valid` mid-tile.
- Skew: lane i is a chain of i+1 registers; lane 0 has 1 register, lane LANES-1 has LANES registers.
  - Each cycle with `en=1`, the chain input is loaded with the accepted data and valid=1.
  - Otherwise the chain input is loaded with data 0 and valid=0 (a bubble).
  - Bubbles propagate skewed like data.
- `out_data` lane is 0 whenever that lane's valid is 0. The array never sees stale data.
- Beat counter width: $clog2(INNER_DIMENSION). It wraps to 0 on entering DRAIN.
- Drain counter width: $clog2(LANES). It counts `en` cycles in DRAIN.
- `busy = (state != IDLE) || |out_lane_valid`.
- Back-to-back tiles: the next tile is accepted only after returning to IDLE. No overlap. Minimum inter-tile gap is LANES cycles.

## Timing
- Reset values: all chain registers 0, `out_data`=0, `out_lane_valid`=0, `tile_done`=0, `busy`=0, `len_err`=0, state IDLE, counters 0. `in_ready` equals `en` in the cycle after reset.
- Latency: a beat accepted in cycle t appears on lane i in cycle t+1+i (with `en` continuously high).
- `tile_done`:
  - Asserts in the same cycle as `out_lane_valid[LANES-1]` for beat K.
  - That cycle is LANES cycles after the last acceptance.
  - FSM is IDLE in the following cycle.
- `en=0`: all state, counters and outputs hold. `in_ready`=0. `tile_done` held high stays high until the next `en` cycle, then clears.
- `rst` mid-tile: the pipeline is flushed to zeros immediately, the partial tile is discarded, and no `tile_done` is issued.
- `LANES=1`: single register stage. Drain lasts 1 cycle.

## Configuration
- `SYSTOLIC_FEEDER_CHECK_EN` defined:
  - `len_err` sets if `in_last` is 1 on an accepted beat other than beat K.
  - `len_err` also sets if `in_last` is 0 on beat K.
  - `len_err` is sticky until `rst`. Framing is still governed by the counter only.
- Macro undefined: `len_err` port and its logic are absent, and `in_last` is ignored (the port remains).

## Structure
- Shared package `systolic_pkg`:
  - FSM state enum `feeder_state_t`.
  - Helper function for lane slicing of packed vectors.
  - Reused by the weight-side feeder and the output collector.
- One sub-module, `skew_delay_line`: parameterised depth and width, with an enable, carrying data plus valid. Instantiated per lane in a generate loop.

## Test plan
All scenarios use LANES=4, INNER_DIMENSION=3, DATA_WIDTH=8.
- Beats {11,12,13,14}, {21,22,23,24}, {31,32,33,34} back-to-back from cycle 0 → lane0 emits 11,21,31 at cycles 1-3; lane3 emits 14,24,34 at cycles 4-6; `tile_done`=1 at cycle 6; `busy` low at cycle 7.
- Same tile with `in_valid` low for one cycle between beats 1 and 2 → a zero/invalid bubble appears on each lane, one cycle later per lane; `tile_done` at cycle 7.
- `en` dropped for 2 cycles mid-tile → outputs frozen, `in_ready`=0 during the stall; every subsequent event shifts by exactly 2 cycles.
- `in_valid` held high during DRAIN → `in_ready`=0 for 4 cycles; the next tile is accepted in the cycle after `tile_done`.
- `rst` asserted after beat 2 → next cycle: all outputs 0, IDLE state, no `tile_done` issued.
- With macro: `in_last`=1 on beat 2 → `len_err`=1 from the next cycle and held through the tile; without macro, tile completes identically to the first scenario.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array edge feeders and collectors.
// Used by the operand feeder, the weight-side feeder and the output collector.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_t;

    // LSB position of a lane inside a packed multi-lane vector.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth delay line carrying data plus a valid qualifier, frozen when en is low.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             tap_valid,
    output logic [WIDTH-1:0] tap_data
);

    logic [WIDTH-1:0] data_r  [DEPTH];
    logic [DEPTH-1:0] valid_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= '0;
            end
            valid_r <= '0;
        end else if (en) begin
            data_r[0]  <= load_data;
            valid_r[0] <= load_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_r[i]  <= data_r[i-1];
                valid_r[i] <= valid_r[i-1];
            end
        end
    end

    assign tap_valid = valid_r[DEPTH-1];
    assign tap_data  = data_r[DEPTH-1];

endmodule

// File: rtl/systolic_operand_feeder.sv
// Row-operand skew stage for the systolic array: frames K-beat tiles and skews lane i by i cycles.
// Optional framing check on in_last is built when SYSTOLIC_FEEDER_CHECK_EN is defined.
module systolic_operand_feeder
    import systolic_pkg::*;
#(
    parameter int LANES           = 50,
    parameter int INNER_DIMENSION = 50,
    parameter int DATA_WIDTH      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic                        in_last,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic [LANES-1:0]            out_lane_valid,
    output logic                        busy,
    output feeder_state_t               state,
    output logic                        tile_done
`ifdef SYSTOLIC_FEEDER_CHECK_EN
    ,
    output logic                        len_err
`endif
);

    localparam int BEAT_W  = (INNER_DIMENSION > 1) ? $clog2(INNER_DIMENSION) : 1;
    localparam int DRAIN_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(INNER_DIMENSION - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(LANES - 1);

    logic [BEAT_W-1:0]  beat_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               accept;
    logic               final_beat;

    assign in_ready   = en && (state != DRAIN);
    assign accept     = in_valid && in_ready;
    assign final_beat = (beat_cnt == BEAT_LAST);

    // tile_done is registered, so it is launched one drain step early to coincide
    // with the final beat reaching the last lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            tile_done <= 1'b0;
        end else if (en) begin
            tile_done <= 1'b0;
            case (state)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (final_beat) begin
                            state     <= DRAIN;
                            beat_cnt  <= '0;
                            drain_cnt <= '0;
                            tile_done <= (LANES == 1);
                        end else begin
                            state    <= STREAM;
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state     <= IDLE;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                        tile_done <= (drain_cnt == DRAIN_LAST - 1'b1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SYSTOLIC_FEEDER_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            len_err <= 1'b0;
        end else if (accept && (in_last != final_beat)) begin
            len_err <= 1'b1;
        end
    end
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
`endif

    // Bubbles enter as zero data so the array never sees stale operands.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [DATA_WIDTH-1:0] load_data;
        assign load_data = accept ? in_data[lane_lsb(g, DATA_WIDTH) +: DATA_WIDTH] : '0;

        skew_delay_line #(
            .DEPTH(g + 1),
            .WIDTH(DATA_WIDTH)
        ) u_line (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .load_valid(accept),
            .load_data (load_data),
            .tap_valid (out_lane_valid[g]),
            .tap_data  (out_data[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign busy = (state != IDLE) || (|out_lane_valid);

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder with a cycle-level reference model.
`timescale 1ns/1ps
module tb_systolic_operand_feeder;
    import systolic_pkg::*;

    localparam int LANES = 4;
    localparam int K     = 3;
    localparam int DW    = 8;
    localparam int W     = LANES * DW;

    localparam logic [W-1:0] B1 = 32'h0E0D0C0B;  // 11,12,13,14 (lane0 in LSB)
    localparam logic [W-1:0] B2 = 32'h18171615;  // 21..24
    localparam logic [W-1:0] B3 = 32'h2221201F;  // 31..34
    localparam logic [W-1:0] B4 = 32'h2C2B2A29;  // 41..44

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic [LANES-1:0] out_lane_valid;
    logic          busy;
    logic          tile_done;
    feeder_state_t state;
`ifdef SYSTOLIC_FEEDER_CHECK_EN
    logic          len_err;
`endif

    always #5 clk = ~clk;

    systolic_operand_feeder #(
        .LANES(LANES),
        .INNER_DIMENSION(K),
        .DATA_WIDTH(DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_data      (out_data),
        .out_lane_valid(out_lane_valid),
        .busy          (busy),
        .state         (state),
        .tile_done     (tile_done)
`ifdef SYSTOLIC_FEEDER_CHECK_EN
        ,
        .len_err       (len_err)
`endif
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] lane(input logic [W-1:0] d, input int i);
        return d[i*DW +: DW];
    endfunction

    // ---------------- reference model ----------------
    // History of chain inputs, newest first: lane i shows entry i.
    logic [W-1:0] exp_q[$];
    logic         vld_q[$];
    logic         last_q[$];
    int           beats = 0;   // beats accepted in the open tile
    int           blk   = 0;   // remaining en-cycles of drain
    logic         err_m = 1'b0;
    logic         acc_m;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            vld_q.delete();
            last_q.delete();
            beats = 0;
            blk   = 0;
            err_m = 1'b0;
        end else if (en) begin
            acc_m = in_valid && (blk == 0);
            exp_q.push_front(acc_m ? in_data : '0);
            vld_q.push_front(acc_m);
            last_q.push_front(acc_m && (beats == K - 1));
            if (exp_q.size() > LANES) begin
                void'(exp_q.pop_back());
                void'(vld_q.pop_back());
                void'(last_q.pop_back());
            end
            if (acc_m && (in_last != (beats == K - 1))) err_m = 1'b1;
            if (blk > 0) blk--;
            if (acc_m) begin
                if (beats == K - 1) begin
                    beats = 0;
                    blk   = LANES;
                end else begin
                    beats++;
                end
            end
        end
    end

    logic [W-1:0]     exp_data;
    logic [W-1:0]     hist_v;
    logic [LANES-1:0] exp_vld;
    logic             exp_td;
    feeder_state_t    exp_st;

    always @(negedge clk) begin
        if (chk_on) begin
            exp_data = '0;
            exp_vld  = '0;
            exp_td   = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                if (i < exp_q.size()) begin
                    hist_v = exp_q[i];
                    exp_data[i*DW +: DW] = hist_v[i*DW +: DW];
                    exp_vld[i] = vld_q[i];
                end
            end
            if (exp_q.size() >= LANES) exp_td = last_q[LANES-1];
            exp_st = (blk > 0) ? DRAIN : ((beats > 0) ? STREAM : IDLE);
            check("out_data", out_data, exp_data);
            check("out_lane_valid", out_lane_valid, exp_vld);
            check("tile_done", tile_done, exp_td);
            check("busy", busy, (blk > 0) || (beats > 0) || (|exp_vld));
            check("in_ready", in_ready, en && (blk == 0));
            check("state", state, exp_st);
`ifdef SYSTOLIC_FEEDER_CHECK_EN
            check("len_err", len_err, err_m);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    logic [W-1:0]     cap_d   [16];
    logic [LANES-1:0] cap_v   [16];
    logic             cap_td  [16];
    logic             cap_bz  [16];
    logic             cap_rdy [16];
    feeder_state_t    cap_st  [16];
    logic             cap_err [16];

    task automatic step(input int c, input logic r, input logic v, input logic e,
                        input logic [W-1:0] d, input logic l);
        @(posedge clk);
        #1;
        rst = r; in_valid = v; en = e; in_data = d; in_last = l;
        @(negedge clk);
        cap_d[c]   = out_data;
        cap_v[c]   = out_lane_valid;
        cap_td[c]  = tile_done;
        cap_bz[c]  = busy;
        cap_rdy[c] = in_ready;
        cap_st[c]  = state;
`ifdef SYSTOLIC_FEEDER_CHECK_EN
        cap_err[c] = len_err;
`else
        cap_err[c] = 1'b0;
`endif
    endtask

    task automatic do_reset();
        step(15, 1'b1, 1'b0, 1'b1, '0, 1'b0);
        step(15, 1'b1, 1'b0, 1'b1, '0, 1'b0);
    endtask

    // Back-to-back tile; bad_last moves in_last from beat 3 onto beat 2.
    task automatic run_s1(input logic bad_last);
        do_reset();
        step(0, 1'b0, 1'b1, 1'b1, B1, 1'b0);
        step(1, 1'b0, 1'b1, 1'b1, B2, bad_last);
        step(2, 1'b0, 1'b1, 1'b1, B3, !bad_last);
        for (int c = 3; c <= 7; c++) step(c, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        check("s1_c0_data_zero", cap_d[0], '0);
        check("s1_lane0_c1", lane(cap_d[1], 0), 8'd11);
        check("s1_lane0_c2", lane(cap_d[2], 0), 8'd21);
        check("s1_lane0_c3", lane(cap_d[3], 0), 8'd31);
        check("s1_lane3_c4", lane(cap_d[4], 3), 8'd14);
        check("s1_lane3_c5", lane(cap_d[5], 3), 8'd24);
        check("s1_lane3_c6", lane(cap_d[6], 3), 8'd34);
        check("s1_done_c5", cap_td[5], 1'b0);
        check("s1_done_c6", cap_td[6], 1'b1);
        check("s1_busy_c7", cap_bz[7], 1'b0);
        check("s1_state_c7", cap_st[7], IDLE);
`ifdef SYSTOLIC_FEEDER_CHECK_EN
        check("s6_err_c1", cap_err[1], 1'b0);
        check("s6_err_c2", cap_err[2], bad_last);
        check("s6_err_c7", cap_err[7], bad_last);
`endif
    endtask

    // ---------------- directed scenarios ----------------
    int zeros;
    logic any_td;

    initial begin
        do_reset();
        chk_on = 1'b1;
        step(0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        check("rst_out_data", cap_d[0], '0);
        check("rst_valid", cap_v[0], '0);
        check("rst_tile_done", cap_td[0], 1'b0);
        check("rst_busy", cap_bz[0], 1'b0);
        check("rst_ready", cap_rdy[0], 1'b1);
        check("rst_state", cap_st[0], IDLE);
        step(1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("ready_en_low", cap_rdy[1], 1'b0);

        run_s1(1'b0);

        // one-cycle in_valid gap between beats 1 and 2
        do_reset();
        step(0, 1'b0, 1'b1, 1'b1, B1, 1'b0);
        step(1, 1'b0, 1'b0, 1'b1, B2, 1'b0);
        step(2, 1'b0, 1'b1, 1'b1, B2, 1'b0);
        step(3, 1'b0, 1'b1, 1'b1, B3, 1'b1);
        for (int c = 4; c <= 8; c++) step(c, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        check("s2_lane0_bubble", lane(cap_d[2], 0), 8'd0);
        check("s2_lane0_bubble_v", cap_v[2][0], 1'b0);
        check("s2_lane1_c2", lane(cap_d[2], 1), 8'd12);
        check("s2_lane1_bubble_v", cap_v[3][1], 1'b0);
        check("s2_lane1_c4", lane(cap_d[4], 1), 8'd22);
        check("s2_lane3_bubble_v", cap_v[5][3], 1'b0);
        check("s2_lane3_c6", lane(cap_d[6], 3), 8'd24);
        check("s2_done_c6", cap_td[6], 1'b0);
        check("s2_done_c7", cap_td[7], 1'b1);

        // en low for two cycles mid-tile
        do_reset();
        step(0, 1'b0, 1'b1, 1'b1, B1, 1'b0);
        step(1, 1'b0, 1'b1, 1'b1, B2, 1'b0);
        step(2, 1'b0, 1'b1, 1'b0, B3, 1'b1);
        step(3, 1'b0, 1'b1, 1'b0, B3, 1'b1);
        step(4, 1'b0, 1'b1, 1'b1, B3, 1'b1);
        for (int c = 5; c <= 10; c++) step(c, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        check("s3_ready_c2", cap_rdy[2], 1'b0);
        check("s3_ready_c3", cap_rdy[3], 1'b0);
        check("s3_frozen_c2", cap_d[2], 32'h00000C15);
        check("s3_frozen_c3", cap_d[3], 32'h00000C15);
        check("s3_frozen_c4", cap_d[4], 32'h00000C15);
        check("s3_lane0_c5", lane(cap_d[5], 0), 8'd31);
        check("s3_lane3_c6", lane(cap_d[6], 3), 8'd14);
        check("s3_done_c7", cap_td[7], 1'b0);
        check("s3_done_c8", cap_td[8], 1'b1);

        // in_valid held high through drain; next tile starts after tile_done
        do_reset();
        step(0, 1'b0, 1'b1, 1'b1, B1, 1'b0);
        step(1, 1'b0, 1'b1, 1'b1, B2, 1'b0);
        step(2, 1'b0, 1'b1, 1'b1, B3, 1'b1);
        for (int c = 3; c <= 9; c++) step(c, 1'b0, 1'b1, 1'b1, B4, c == 9);
        for (int c = 10; c <= 14; c++) step(c, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        zeros = 0;
        for (int c = 3; c <= 6; c++) if (cap_rdy[c] === 1'b0) zeros++;
        check("s4_ready_low_cycles", zeros, 4);
        check("s4_done_c6", cap_td[6], 1'b1);
        check("s4_ready_c7", cap_rdy[7], 1'b1);
        check("s4_state_c8", cap_st[8], STREAM);
        check("s4_lane0_c8", lane(cap_d[8], 0), 8'd41);
        check("s4_done_c13", cap_td[13], 1'b1);

        // reset after beat 2 discards the partial tile
        do_reset();
        step(0, 1'b0, 1'b1, 1'b1, B1, 1'b0);
        step(1, 1'b0, 1'b1, 1'b1, B2, 1'b0);
        step(2, 1'b1, 1'b1, 1'b1, B3, 1'b1);
        for (int c = 3; c <= 9; c++) step(c, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        check("s5_lane0_c2", lane(cap_d[2], 0), 8'd21);
        check("s5_data_c3", cap_d[3], '0);
        check("s5_valid_c3", cap_v[3], '0);
        check("s5_state_c3", cap_st[3], IDLE);
        check("s5_busy_c3", cap_bz[3], 1'b0);
        check("s5_ready_c3", cap_rdy[3], 1'b1);
        any_td = 1'b0;
        for (int c = 3; c <= 9; c++) any_td = any_td | cap_td[c];
        check("s5_no_tile_done", any_td, 1'b0);

        // in_last on beat 2: flags len_err with the check built, otherwise ignored
        run_s1(1'b1);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
